// File: rtl/arbiter_rr8.sv
// arbiter_rr8: eight-way round-robin arbiter with registered grant index,
// break-before-make release and MAX_HOLD-bounded grants under contention.
module dec3to8 (
    input  logic [2:0] a,
    output logic [7:0] y
);
    assign y = 8'd1 << a;
endmodule

module arbiter_rr8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       preempt
);
    typedef enum logic {ARB, HOLD} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    state_t state, state_nx;
    logic [2:0] ptr, ptr_nx, idx_nx, off, winner;
    logic [7:0] hold_cnt, cnt_nx, rot, others, dec;
    logic valid_nx, pre_nx, last, vol, forced;
    // Rotate so bit 0 is the requester at ptr; first set bit gives the offset.
    assign rot = (req >> ptr) | (req << (4'd8 - {1'b0, ptr}));
    always_comb begin
        off = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) off = 3'(i);
    end
    assign winner = ptr + off;
    dec3to8 u_dec (.a(grant_idx), .y(dec));
    assign grant  = dec & {8{grant_valid}};
    assign others = req & ~dec;
    assign last   = hold_cnt == HOLD_LAST;
    assign vol    = !req[grant_idx];
    assign forced = !vol && last && others != 8'd0;
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = hold_cnt;
        idx_nx   = grant_idx;
        valid_nx = grant_valid;
        pre_nx   = 1'b0;
        if (state == ARB) begin
            valid_nx = req != 8'd0;
            if (req != 8'd0) begin
                state_nx = HOLD;
                idx_nx   = winner;
                cnt_nx   = 8'd0;
            end
        end else if (vol || forced) begin
            state_nx = ARB;
            valid_nx = 1'b0;
            pre_nx   = forced;
            ptr_nx   = grant_idx + 3'd1;
        end else begin
            cnt_nx = last ? hold_cnt : hold_cnt + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB;
            ptr         <= 3'd0;
            hold_cnt    <= 8'd0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            hold_cnt    <= cnt_nx;
            grant_idx   <= idx_nx;
            grant_valid <= valid_nx;
            preempt     <= pre_nx;
        end
    end
endmodule

// File: tb/tb_arbiter_rr8.sv
// tb_arbiter_rr8: directed and random stimulus scored against a behavioural
// round-robin model; expectations are queued and checked by a monitor.
module tb_arbiter_rr8;
    localparam int MH = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic grant_valid, preempt;

    arbiter_rr8 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .grant_idx(grant_idx), .grant_valid(grant_valid), .preempt(preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       p;
        bit         ci;
    } exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0;

    bit m_busy = 0, m_pre = 0;
    int m_own = 0, m_ptr = 0, m_held = 0;

    function automatic int first_from(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic cyc(input logic [7:0] r, input logic rn);
        exp_t e;
        logic [7:0] others;
        @(negedge clk);
        req = r;
        rst_n = rn;
        others = r & ~(8'd1 << m_own);
        if (!rn) begin
            m_busy = 0; m_own = 0; m_ptr = 0; m_held = 0; m_pre = 0;
        end else if (!m_busy) begin
            m_pre = 0;
            if (r != 8'd0) begin
                m_busy = 1; m_own = first_from(r, m_ptr); m_held = 0;
            end
        end else begin
            m_pre = 0;
            if (!r[m_own]) begin
                m_busy = 0; m_ptr = (m_own + 1) % 8;
            end else if (m_held >= MH - 1 && others != 8'd0) begin
                m_busy = 0; m_pre = 1; m_ptr = (m_own + 1) % 8;
            end else if (m_held < MH - 1) begin
                m_held++;
            end
        end
        e.g   = m_busy ? 8'd1 << m_own : 8'd0;
        e.idx = 3'(m_own);
        e.v   = m_busy;
        e.p   = m_pre;
        e.ci  = m_busy || !rn;
        q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("grant", grant, e.g);
            chk("grant_valid", {7'd0, grant_valid}, {7'd0, e.v});
            chk("preempt", {7'd0, preempt}, {7'd0, e.p});
            if (e.ci) chk("grant_idx", {5'd0, grant_idx}, {5'd0, e.idx});
        end
    end

    initial begin
        logic [7:0] r;
        // reset with all requesting, then first grant goes to 0
        cyc(8'hFF, 0);
        cyc(8'hFF, 0);
        // rotation: each grantee drops after 3 cycles and re-requests after the gap
        for (int i = 0; i < 36; i++) begin
            r = 8'hFF;
            if (m_busy && m_held == 2) r[m_own] = 1'b0;
            cyc(r, 1);
        end
        // wrap-around: serve 5, then 0 and 5 contend from ptr=6, then from ptr=1
        cyc(8'h00, 0);
        cyc(8'h20, 1);
        cyc(8'h20, 1);
        cyc(8'h00, 1);
        cyc(8'h21, 1);
        cyc(8'h21, 1);
        cyc(8'h20, 1);
        cyc(8'h21, 1);
        cyc(8'h21, 1);
        cyc(8'h00, 1);
        // forced release between two constant requesters
        cyc(8'h00, 0);
        for (int i = 0; i < 22; i++) cyc(8'h03, 1);
        // sole requester holds indefinitely, then a second one forces release
        cyc(8'h00, 0);
        for (int i = 0; i < 20; i++) cyc(8'h08, 1);
        for (int i = 0; i < 4; i++) cyc(8'h0A, 1);
        // reset mid-grant while 3 is granted
        cyc(8'h00, 0);
        cyc(8'h08, 1);
        cyc(8'h0B, 1);
        cyc(8'h0B, 0);
        cyc(8'h0B, 1);
        cyc(8'h0B, 1);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            cyc(8'($urandom) & 8'($urandom | ($urandom_range(0, 3) == 0 ? 0 : 32'hFF)),
                $urandom_range(0, 59) != 0);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
